// File: rtl/ws2812_strand_driver_if.sv
// Generator handshake for ws2812_strand_driver: the driver requests an LED index,
// and the pattern generator answers with that LED's colour.
interface ws2812_strand_driver_if #(
  parameter int unsigned NUM_LEDS    = 20,
  parameter int unsigned COLOR_WIDTH = 8
);
  localparam int unsigned LED_COUNTER_WIDTH = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  logic [LED_COUNTER_WIDTH-1:0] next_led_request;
  logic                         request_valid;
  logic [COLOR_WIDTH-1:0]       green_in;
  logic [COLOR_WIDTH-1:0]       red_in;
  logic [COLOR_WIDTH-1:0]       blue_in;
  logic                         color_ready;

  modport master (
    output next_led_request,
    output request_valid,
    input  green_in,
    input  red_in,
    input  blue_in,
    input  color_ready
  );

  modport slave (
    input  next_led_request,
    input  request_valid,
    output green_in,
    output red_in,
    output blue_in,
    output color_ready
  );
endinterface

// File: rtl/ws2812_strand_driver.sv
// WS2812B one-wire NRZ strand driver: fetches each LED colour, shifts it out MSB first (G,R,B).
// Optional macro WS2812_INVERT_OUT_EN inverts strand_out (reset level 1) for inverting buffers.
module ws2812_strand_driver #(
  parameter int unsigned CLOCK_SPEED = 100_000_000,
  parameter int unsigned NUM_LEDS    = 20,
  parameter int unsigned COLOR_WIDTH = 8,
  parameter int unsigned T0H_NS      = 400,
  parameter int unsigned T0L_NS      = 850,
  parameter int unsigned T1H_NS      = 800,
  parameter int unsigned T1L_NS      = 450,
  parameter int unsigned LATCH_US    = 80,
  parameter int unsigned REQ_LATENCY = 1
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  ws2812_strand_driver_if.master        gen_if,
  output logic                          strand_out,
  output logic                          frame_done,
  output logic                          busy
);

  localparam int unsigned LED_COUNTER_WIDTH = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int unsigned BITS_PER_LED      = 3 * COLOR_WIDTH;
  localparam int unsigned BIT_IDX_WIDTH     = $clog2(BITS_PER_LED);

  localparam int unsigned CYC_PER_US = CLOCK_SPEED / 1_000_000;
  localparam int unsigned T0H_CYC    = CYC_PER_US * T0H_NS / 1000;
  localparam int unsigned T0L_CYC    = CYC_PER_US * T0L_NS / 1000;
  localparam int unsigned T1H_CYC    = CYC_PER_US * T1H_NS / 1000;
  localparam int unsigned T1L_CYC    = CYC_PER_US * T1L_NS / 1000;
  localparam int unsigned LATCH_CYC  = CYC_PER_US * LATCH_US;
  localparam int unsigned FETCH_CYC  = REQ_LATENCY + 1;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_CYC = max2(max2(max2(LATCH_CYC, FETCH_CYC),
                                              max2(T0H_CYC, T0L_CYC)),
                                         max2(T1H_CYC, T1L_CYC));
  localparam int unsigned TIMER_WIDTH = $clog2(MAX_CYC + 1);

  localparam logic [TIMER_WIDTH-1:0] LATCH_LAST = TIMER_WIDTH'(LATCH_CYC - 1);
  localparam logic [TIMER_WIDTH-1:0] FETCH_LAST = TIMER_WIDTH'(FETCH_CYC - 1);
  localparam logic [TIMER_WIDTH-1:0] T0H_LAST   = TIMER_WIDTH'(T0H_CYC - 1);
  localparam logic [TIMER_WIDTH-1:0] T0L_LAST   = TIMER_WIDTH'(T0L_CYC - 1);
  localparam logic [TIMER_WIDTH-1:0] T1H_LAST   = TIMER_WIDTH'(T1H_CYC - 1);
  localparam logic [TIMER_WIDTH-1:0] T1L_LAST   = TIMER_WIDTH'(T1L_CYC - 1);

  localparam logic [BIT_IDX_WIDTH-1:0]     BIT_LAST = BIT_IDX_WIDTH'(BITS_PER_LED - 1);
  localparam logic [LED_COUNTER_WIDTH-1:0] LED_LAST = LED_COUNTER_WIDTH'(NUM_LEDS - 1);

`ifdef WS2812_INVERT_OUT_EN
  localparam logic OUT_INVERT = 1'b1;
`else
  localparam logic OUT_INVERT = 1'b0;
`endif

  typedef enum logic [1:0] {
    StLatch,
    StFetch,
    StSendH,
    StSendL
  } state_e;

  state_e                         r_state;
  logic [TIMER_WIDTH-1:0]         r_timer;
  logic [LED_COUNTER_WIDTH-1:0]   r_led_idx;
  logic [BIT_IDX_WIDTH-1:0]       r_bit_idx;
  logic [BITS_PER_LED-1:0]        r_shift;
  logic                           r_strand;

  state_e                         w_state_d;
  logic [TIMER_WIDTH-1:0]         w_timer_d;
  logic [LED_COUNTER_WIDTH-1:0]   w_led_idx_d;
  logic [BIT_IDX_WIDTH-1:0]       w_bit_idx_d;
  logic [BITS_PER_LED-1:0]        w_shift_d;
  logic                           w_strand_d;
  logic                           w_frame_done;
  logic                           w_bit_one;
  logic [TIMER_WIDTH-1:0]         w_high_last;
  logic [TIMER_WIDTH-1:0]         w_low_last;

  assign w_bit_one   = r_shift[BITS_PER_LED-1];
  assign w_high_last = w_bit_one ? T1H_LAST : T0H_LAST;
  assign w_low_last  = w_bit_one ? T1L_LAST : T0L_LAST;

  always_comb begin
    w_state_d    = r_state;
    w_timer_d    = r_timer + 1'b1;
    w_led_idx_d  = r_led_idx;
    w_bit_idx_d  = r_bit_idx;
    w_shift_d    = r_shift;
    w_frame_done = 1'b0;

    unique case (r_state)
      StLatch: begin
        if (r_timer == LATCH_LAST) begin
          w_frame_done = 1'b1;
          w_led_idx_d  = '0;
          w_timer_d    = '0;
          w_state_d    = StFetch;
        end
      end
      StFetch: begin
        // Colour is only sampled on the last fetch cycle, after the generator latency.
        if (r_timer == FETCH_LAST) begin
          w_shift_d   = gen_if.color_ready ?
                        {gen_if.green_in, gen_if.red_in, gen_if.blue_in} : '0;
          w_bit_idx_d = '0;
          w_timer_d   = '0;
          w_state_d   = StSendH;
        end
      end
      StSendH: begin
        if (r_timer == w_high_last) begin
          w_timer_d = '0;
          w_state_d = StSendL;
        end
      end
      StSendL: begin
        if (r_timer == w_low_last) begin
          w_shift_d = r_shift << 1;
          w_timer_d = '0;
          if (r_bit_idx < BIT_LAST) begin
            w_bit_idx_d = r_bit_idx + 1'b1;
            w_state_d   = StSendH;
          end else if (r_led_idx == LED_LAST) begin
            w_state_d = StLatch;
          end else begin
            w_led_idx_d = r_led_idx + 1'b1;
            w_state_d   = StFetch;
          end
        end
      end
      default: begin
        w_timer_d = '0;
        w_state_d = StLatch;
      end
    endcase
  end

  // Line level is registered from the next state so it is glitch-free and aligned to r_state.
  assign w_strand_d = (w_state_d == StSendH) ^ OUT_INVERT;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= StLatch;
      r_timer   <= '0;
      r_led_idx <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_strand  <= OUT_INVERT;
    end else begin
      r_state   <= w_state_d;
      r_timer   <= w_timer_d;
      r_led_idx <= w_led_idx_d;
      r_bit_idx <= w_bit_idx_d;
      r_shift   <= w_shift_d;
      r_strand  <= w_strand_d;
    end
  end

  assign gen_if.request_valid    = (r_state == StFetch);
  assign gen_if.next_led_request = r_led_idx;
  assign strand_out              = r_strand;
  assign frame_done              = w_frame_done;
  assign busy                    = (r_state == StSendH) || (r_state == StSendL);

endmodule

// File: tb/tb_ws2812_strand_driver.sv
// Scoreboard bench for ws2812_strand_driver: expected LED words are queued when colour tables
// are loaded and popped as the strand waveform is decoded (3 LEDs, 100 MHz timing).
`timescale 1ns/1ps
module tb_ws2812_strand_driver;

  localparam int unsigned NUM_LEDS    = 3;
  localparam int unsigned COLOR_WIDTH = 8;
  localparam int T0H = 40, T0L = 85, T1H = 80, T1L = 45, LATCH = 8000, FETCH = 2;

`ifdef WS2812_INVERT_OUT_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic strand_out, frame_done, busy;

  ws2812_strand_driver_if #(.NUM_LEDS(NUM_LEDS), .COLOR_WIDTH(COLOR_WIDTH)) gen_if ();

  ws2812_strand_driver #(.NUM_LEDS(NUM_LEDS), .COLOR_WIDTH(COLOR_WIDTH)) dut (
    .clk_in     (clk),
    .rst_in     (rst_n),
    .gen_if     (gen_if),
    .strand_out (strand_out),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [23:0] exp_q[$];

  // Colour tables indexed by frame number (count of frame_done pulses since reset).
  logic [23:0] col_tbl [4][4];
  logic        rdy_tbl [4][4];
  logic [3:0]  frame_cnt;
  logic [1:0]  fi;
  logic [23:0] w_col;
  logic        wave;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt <= '0;
    else if (frame_done) frame_cnt <= frame_cnt + 1'b1;
  end

  assign fi                 = (frame_cnt > 4'd3) ? 2'd3 : frame_cnt[1:0];
  assign w_col              = col_tbl[fi][gen_if.next_led_request];
  assign gen_if.green_in    = w_col[23:16];
  assign gen_if.red_in      = w_col[15:8];
  assign gen_if.blue_in     = w_col[7:0];
  assign gen_if.color_ready = rdy_tbl[fi][gen_if.next_led_request];
  assign wave               = strand_out ^ INV;

  task automatic load_frame(input int f, input logic [23:0] c0, input logic r0,
                            input logic [23:0] c1, input logic r1,
                            input logic [23:0] c2, input logic r2);
    col_tbl[f][0] = c0; rdy_tbl[f][0] = r0;
    col_tbl[f][1] = c1; rdy_tbl[f][1] = r1;
    col_tbl[f][2] = c2; rdy_tbl[f][2] = r2;
    exp_q.push_back(r0 ? c0 : 24'h0);
    exp_q.push_back(r1 ? c1 : 24'h0);
    exp_q.push_back(r2 ? c2 : 24'h0);
  endtask

  task automatic test_reset();
    int n;
    int bad_level;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (strand_out !== INV)
      $display("FAIL reset_strand: got %b expected %b", strand_out, INV);
    if (strand_out !== INV) errors++;
    checks++;
    if ({gen_if.request_valid, busy, frame_done, gen_if.next_led_request} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: rv=%b busy=%b fd=%b idx=%0d expected all 0",
               gen_if.request_valid, busy, frame_done, gen_if.next_led_request);
    end
    rst_n = 1'b1;
    n = 0;
    bad_level = 0;
    while (frame_done !== 1'b1 && n < LATCH + 100) begin
      @(negedge clk);
      n++;
      if (wave !== 1'b0 || gen_if.request_valid !== 1'b0) bad_level++;
    end
    checks++;
    if (n != LATCH - 1) begin
      errors++;
      $display("FAIL latch_len: frame_done after %0d samples expected %0d", n, LATCH - 1);
    end
    checks++;
    if (bad_level != 0) begin
      errors++;
      $display("FAIL latch_level: %0d non-low samples expected 0", bad_level);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || gen_if.request_valid !== 1'b1 || gen_if.next_led_request !== 2'd0) begin
      errors++;
      $display("FAIL fetch_after_latch: fd=%b rv=%b idx=%0d expected fd=0 rv=1 idx=0",
               frame_done, gen_if.request_valid, gen_if.next_led_request);
    end
  endtask

  task automatic decode_led(input int led, input bit last, input string tag);
    int k, h, hi, lo, exp_hi, exp_lo, fetch_bad, busy_bad;
    logic [23:0] exp_w, got_w;
    k = 0;
    while (gen_if.request_valid !== 1'b1 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (gen_if.request_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_fetch_timeout: request_valid=%b expected 1", tag, gen_if.request_valid);
    end
    h = 0;
    fetch_bad = 0;
    while (gen_if.request_valid === 1'b1 && h < 16) begin
      if (gen_if.next_led_request != led[1:0] || wave !== 1'b0 || busy !== 1'b0) fetch_bad++;
      h++;
      @(negedge clk);
    end
    checks++;
    if (h != FETCH || fetch_bad != 0) begin
      errors++;
      $display("FAIL %s_fetch: held %0d cycles (%0d bad) expected %0d cycles idx %0d",
               tag, h, fetch_bad, FETCH, led);
    end
    exp_w = 24'h0;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_queue: got empty scoreboard expected a word", tag);
    end else begin
      exp_w = exp_q.pop_front();
    end
    got_w = 24'h0;
    busy_bad = 0;
    for (int b = 0; b < 24; b++) begin
      hi = 0;
      while (wave === 1'b1 && hi < 200) begin
        if (busy !== 1'b1) busy_bad++;
        hi++;
        @(negedge clk);
      end
      lo = 0;
      if (b < 23) begin
        while (wave === 1'b0 && lo < 200) begin
          if (busy !== 1'b1) busy_bad++;
          lo++;
          @(negedge clk);
        end
      end else if (!last) begin
        while (wave === 1'b0 && gen_if.request_valid !== 1'b1 && lo < 200) begin
          lo++;
          @(negedge clk);
        end
      end else begin
        while (wave === 1'b0 && frame_done !== 1'b1 && lo < LATCH + 500) begin
          lo++;
          @(negedge clk);
        end
      end
      got_w  = {got_w[22:0], (hi == T1H)};
      exp_hi = exp_w[23 - b] ? T1H : T0H;
      exp_lo = (exp_w[23 - b] ? T1L : T0L) + ((b == 23 && last) ? LATCH - 1 : 0);
      checks++;
      if (hi != exp_hi) begin
        errors++;
        $display("FAIL %s_b%0d_high: got %0d cycles expected %0d", tag, b, hi, exp_hi);
      end
      checks++;
      if (lo != exp_lo) begin
        errors++;
        $display("FAIL %s_b%0d_low: got %0d cycles expected %0d", tag, b, lo, exp_lo);
      end
    end
    checks++;
    if (got_w !== exp_w) begin
      errors++;
      $display("FAIL %s_word: got %06h expected %06h", tag, got_w, exp_w);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("FAIL %s_busy: %0d samples with busy low expected 0", tag, busy_bad);
    end
  endtask

  task automatic check_restart(input string tag);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_frame_done: got %b expected 1", tag, frame_done);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || gen_if.request_valid !== 1'b1 || gen_if.next_led_request !== 2'd0) begin
      errors++;
      $display("FAIL %s_restart: fd=%b rv=%b idx=%0d expected fd=0 rv=1 idx=0",
               tag, frame_done, gen_if.request_valid, gen_if.next_led_request);
    end
  endtask

  task automatic test_color_timing();
    decode_led(0, 1'b0, "f1_led0_color");
  endtask

  task automatic test_black_substitution();
    decode_led(1, 1'b0, "f1_led1_black");
  endtask

  task automatic test_frame_sequencing();
    decode_led(2, 1'b1, "f1_led2");
    check_restart("f1");
  endtask

  task automatic test_back_to_back();
    decode_led(0, 1'b0, "f2_led0");
    decode_led(1, 1'b0, "f2_led1");
    decode_led(2, 1'b1, "f2_led2_notready");
    check_restart("f2");
  endtask

  task automatic test_async_reset();
    int k;
    k = 0;
    while (!(gen_if.request_valid === 1'b1 && gen_if.next_led_request == 2'd1) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    while (gen_if.request_valid === 1'b1 && k < 20000) begin
      @(negedge clk);
      k++;
    end
    repeat (10) @(negedge clk);
    checks++;
    if (wave !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL arst_in_send_h: wave=%b busy=%b expected 1 1", wave, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (strand_out !== INV || busy !== 1'b0 || gen_if.request_valid !== 1'b0 ||
        frame_done !== 1'b0 || gen_if.next_led_request !== 2'd0) begin
      errors++;
      $display("FAIL arst_immediate: strand=%b busy=%b rv=%b fd=%b idx=%0d expected %b 0 0 0 0",
               strand_out, busy, gen_if.request_valid, frame_done,
               gen_if.next_led_request, INV);
    end
    test_reset();
  endtask

  initial begin
    for (int f = 0; f < 4; f++) begin
      for (int l = 0; l < 4; l++) begin
        col_tbl[f][l] = 24'h0;
        rdy_tbl[f][l] = 1'b0;
      end
    end
    load_frame(1, 24'h800001, 1'b1, 24'hFFFFFF, 1'b0, 24'hA53C5A, 1'b1);
    load_frame(2, 24'hFFFFFF, 1'b1, 24'h00FF00, 1'b1, 24'h123456, 1'b0);
    col_tbl[3][1] = 24'hFFFFFF;
    rdy_tbl[3][1] = 1'b1;

    test_reset();
    test_color_timing();
    test_black_substitution();
    test_frame_sequencing();
    test_back_to_back();
    test_async_reset();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d words left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
